// File: rtl/imm_gen_pkg.sv
// Shared types for the registered immediate generator: instruction formats,
// RV opcodes, FSM states and the buffered result entry.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  // Type-only wrapper so the entry layout can follow the instance's XLEN/TAG_W.
  virtual class entry_c #(parameter int XLEN = 32, parameter int TAG_W = 4);
    typedef struct packed {
      logic [XLEN-1:0]  imm;
      fmt_e             fmt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
    } entry_t;
  endclass

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream instruction and downstream result handshakes of imm_gen_pipe.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  import imm_gen_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  fmt_e             out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_decode.sv
// Combinational RV format classifier and sign-extended immediate extractor.
// Illegal-encoding detection is only built when IMM_GEN_ILLEGAL_EN is defined.
module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);
  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  opc;
  logic [31:0] imm32;

  assign opc = inst_i[6:0];

  always_comb begin
    fmt_o = FMT_NONE;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: fmt_o = FMT_I;
      OPC_OPIMM32:                               if (RV64) fmt_o = FMT_I;
      OPC_STORE:                                 fmt_o = FMT_S;
      OPC_BRANCH:                                fmt_o = FMT_B;
      OPC_LUI, OPC_AUIPC:                        fmt_o = FMT_U;
      OPC_JAL:                                   fmt_o = FMT_J;
      default:                                   fmt_o = FMT_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt_o)
      FMT_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      FMT_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      FMT_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      FMT_U:   imm32 = {inst_i[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every format's 32-bit immediate already carries inst[31] in its MSB.
  assign imm_o = XLEN'($signed(imm32));

`ifdef IMM_GEN_ILLEGAL_EN
  always_comb begin
    illegal_o = 1'b1;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP:        illegal_o = 1'b0;
      OPC_OPIMM32, OPC_OP32:                       illegal_o = !RV64;
      default:                                     illegal_o = 1'b1;
    endcase
  end
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid (output reg + skid reg).
// Optional illegal-encoding flag: define IMM_GEN_ILLEGAL_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  imm_gen_pipe_if.slave bus
);
  typedef entry_c#(XLEN, TAG_W)::entry_t entry_t;

  state_e          state_q, state_d;
  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  entry_t          dec_e;
  logic            in_ready_q, in_ready_d;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;
  logic            accept;
  logic            drain;

  imm_gen_decode #(.XLEN(XLEN)) u_decode (
    .inst_i    (bus.in_inst),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  assign dec_e  = {dec_imm, dec_fmt, dec_ill, bus.in_tag};
  assign accept = bus.in_valid && in_ready_q;
  assign drain  = (state_q != ST_EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = dec_e;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_d = dec_e;
          end else if (accept) begin
            skid_d  = dec_e;
            state_d = ST_TWO;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can move the state.
          if (drain) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != ST_EMPTY);
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, directed vectors.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

`ifdef IMM_GEN_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [3:0]  tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));

  function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endfunction

  // Monitors: pop one expectation per handshake on the output side.
  always @(negedge clk) begin
    if (rst_n && !flush && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL m32_extra: got output tag %0d, required none", b32.out_tag);
      end else begin
        e32 = q32.pop_front();
        $display("out32 tag=%0d imm=0x%h fmt=%0d ill=%0b", b32.out_tag, b32.out_imm, b32.out_fmt, b32.out_illegal);
        check("m32_imm", 64'(b32.out_imm), e32.imm);
        check("m32_fmt", 64'(b32.out_fmt), 64'(e32.fmt));
        check("m32_ill", 64'(b32.out_illegal), 64'(e32.ill));
        check("m32_tag", 64'(b32.out_tag), 64'(e32.tag));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && !flush && b64.out_valid && b64.out_ready) begin
      if (q64.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL m64_extra: got output tag %0d, required none", b64.out_tag);
      end else begin
        e64 = q64.pop_front();
        $display("out64 tag=%0d imm=0x%h fmt=%0d ill=%0b", b64.out_tag, b64.out_imm, b64.out_fmt, b64.out_illegal);
        check("m64_imm", b64.out_imm, e64.imm);
        check("m64_fmt", 64'(b64.out_fmt), 64'(e64.fmt));
        check("m64_ill", 64'(b64.out_illegal), 64'(e64.ill));
        check("m64_tag", 64'(b64.out_tag), 64'(e64.tag));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input bit w, input logic [31:0] inst, input logic [3:0] tag,
                      input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    int k = 0;
    bit rdy;
    if (w) begin b64.in_valid = 1'b1; b64.in_inst = inst; b64.in_tag = tag; end
    else   begin b32.in_valid = 1'b1; b32.in_inst = inst; b32.in_tag = tag; end
    rdy = w ? b64.in_ready : b32.in_ready;
    while (!rdy && k < 40) begin
      @(posedge clk); #1;
      k++;
      rdy = w ? b64.in_ready : b32.in_ready;
    end
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles, required 1 (tag %0d)", k, tag);
    end else begin
      @(posedge clk);
      if (w) q64.push_back('{imm: imm, fmt: fmt, ill: ill, tag: tag});
      else   q32.push_back('{imm: imm, fmt: fmt, ill: ill, tag: tag});
      #1;
    end
    if (w) b64.in_valid = 1'b0;
    else   b32.in_valid = 1'b0;
  endtask

  initial begin
    time t0;
    int  k;
    b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_tag = '0; b64.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(b32.out_valid), 64'd0);
    check("rst_ready", 64'(b32.in_ready), 64'd1);
    check("rst_imm",   64'(b32.out_imm), 64'd0);
    check("rst_fmt",   64'(b32.out_fmt), 64'd0);
    check("rst_ill",   64'(b32.out_illegal), 64'd0);
    check("rst_tag",   64'(b32.out_tag), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One-cycle latency: addi x1,x0,-1
    send(0, 32'hFFF00093, 4'd1, 64'hFFFFFFFF, 3'd1, 1'b0);
    check("lat_valid", 64'(b32.out_valid), 64'd1);
    check("lat_tag",   64'(b32.out_tag), 64'd1);

    // Back-to-back stream with out_ready high: 12 vectors in 12 cycles.
    t0 = $time;
    send(0, 32'hFE000EE3, 4'd2,  64'hFFFFFFFC, 3'd3, 1'b0);  // beq -4
    send(0, 32'h00112423, 4'd3,  64'h00000008, 3'd2, 1'b0);  // sw 8
    send(0, 32'hFF012083, 4'd4,  64'hFFFFFFF0, 3'd1, 1'b0);  // lw -16
    send(0, 32'h12345097, 4'd5,  64'h12345000, 3'd4, 1'b0);  // auipc
    send(0, 32'h7FF08067, 4'd6,  64'h000007FF, 3'd1, 1'b0);  // jalr 2047
    send(0, 32'h00000073, 4'd7,  64'h00000000, 3'd1, 1'b0);  // ecall
    send(0, 32'hFE112FA3, 4'd8,  64'hFFFFFFFF, 3'd2, 1'b0);  // sw -1
    send(0, 32'h002081B3, 4'd9,  64'h00000000, 3'd0, 1'b0);  // add
    send(0, 32'hFFFFFFFF, 4'd10, 64'h00000000, 3'd0, ILL);   // opcode 0x7F
    send(0, 32'hFFF00090, 4'd11, 64'h00000000, 3'd0, ILL);   // inst[1:0]=00
    send(0, 32'hFFF0009B, 4'd12, 64'h00000000, 3'd0, ILL);   // addiw on RV32
    send(0, 32'h0020803B, 4'd13, 64'h00000000, 3'd0, ILL);   // addw on RV32
    check("thru_cycles", 64'(($time - t0) / 10), 64'd12);

    // Backpressure: fill both slots, hold a third offer, then release.
    repeat (2) @(posedge clk);
    #1;
    b32.out_ready = 1'b0;
    send(0, 32'h00500093, 4'd10, 64'h00000005, 3'd1, 1'b0);
    send(0, 32'h00112423, 4'd11, 64'h00000008, 3'd2, 1'b0);
    check("bp_full", 64'(b32.in_ready), 64'd0);
    b32.in_valid = 1'b1; b32.in_inst = 32'hFE000EE3; b32.in_tag = 4'd12;
    @(posedge clk); #1;
    check("bp_hold_rdy", 64'(b32.in_ready), 64'd0);
    check("bp_hold_tag", 64'(b32.out_tag), 64'd10);
    check("bp_hold_imm", 64'(b32.out_imm), 64'h5);
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_back", 64'(b32.in_ready), 64'd1);
    check("bp_head_tag",   64'(b32.out_tag), 64'd11);
    send(0, 32'hFE000EE3, 4'd12, 64'hFFFFFFFC, 3'd3, 1'b0);

    // Flush while full with an instruction offered.
    repeat (3) @(posedge clk);
    #1;
    b32.out_ready = 1'b0;
    send(0, 32'h12345097, 4'd13, 64'h12345000, 3'd4, 1'b0);
    send(0, 32'h801FF06F, 4'd14, 64'hFFFFF800, 3'd5, 1'b0);
    b32.in_valid = 1'b1; b32.in_inst = 32'hFFF00093; b32.in_tag = 4'd15;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    q32.delete();
    check("fl_valid", 64'(b32.out_valid), 64'd0);
    check("fl_ready", 64'(b32.in_ready), 64'd1);
    flush = 1'b1;  // in_ready high now: the accept must still lose to flush
    @(posedge clk); #1;
    flush = 1'b0;
    b32.in_valid = 1'b0;
    check("fl_accept", 64'(b32.out_valid), 64'd0);
    b32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("fl_idle", 64'(b32.out_valid), 64'd0);

    // Asynchronous reset while one entry is held.
    b32.out_ready = 1'b0;
    send(0, 32'hFF012083, 4'd9, 64'hFFFFFFF0, 3'd1, 1'b0);
    check("ar_pre", 64'(b32.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(b32.out_valid), 64'd0);
    check("ar_imm",   64'(b32.out_imm), 64'd0);
    check("ar_tag",   64'(b32.out_tag), 64'd0);
    check("ar_fmt",   64'(b32.out_fmt), 64'd0);
    check("ar_ready", 64'(b32.in_ready), 64'd1);
    q32.delete();
    q64.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    b32.out_ready = 1'b1;
    @(posedge clk); #1;

    // XLEN=64 vectors.
    send(1, 32'h800000B7, 4'd1, 64'hFFFFFFFF80000000, 3'd4, 1'b0);  // lui 0x80000
    send(1, 32'h801FF06F, 4'd2, 64'hFFFFFFFFFFFFF800, 3'd5, 1'b0);  // jal -2048
    send(1, 32'hFFF0009B, 4'd3, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);  // addiw -1
    send(1, 32'h0020803B, 4'd4, 64'h0,                3'd0, 1'b0);  // addw
    send(1, 32'hFE000EE3, 4'd5, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);  // beq -4
    send(1, 32'hFFFFFFFF, 4'd6, 64'h0,                3'd0, ILL);   // opcode 0x7F
    send(1, 32'h7FF08067, 4'd7, 64'h00000000000007FF, 3'd1, 1'b0);  // jalr 2047

    k = 0;
    while ((q32.size() != 0 || q64.size() != 0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (q32.size() != 0 || q64.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d/%0d entries outstanding, required 0/0", q32.size(), q64.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
